// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment table for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} for a common-anode display.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-segment decoder shared by all digits of the scan controller.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = seg7_encode(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed common-anode 7-segment scanner: dead-time gap before every digit,
// frame-coherent input snapshot, all outputs registered alongside the FSM state.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned TICKS_PER_DIGIT = 50000,
    parameter int unsigned GUARD_TICKS     = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              disp,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned MAX_TICKS = (TICKS_PER_DIGIT > GUARD_TICKS) ? TICKS_PER_DIGIT : GUARD_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);

    scan_state_t             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_blank_q;
    logic                    snap_load;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              disp_q, disp_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;

    // idx is unchanged on BLANK->DRIVE and within DRIVE, so idx_q selects the digit being driven next.
    assign cur_nibble = snap_digits_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fd_d      = 1'b0;
        snap_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = BLANK;
                    idx_d     = '0;
                    snap_load = 1'b1;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (cnt_q == CNT_W'(GUARD_TICKS - 1)) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (cnt_q == CNT_W'(TICKS_PER_DIGIT - 1)) begin
                    state_d = BLANK;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_d     = '0;
                        fd_d      = 1'b1;
                        snap_load = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (state_d != state_q || state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        an_d   = '1;
        disp_d = SEG_OFF;
        dp_d   = 1'b1;
        if (state_d == DRIVE) begin
            if (!snap_blank_q[idx_q]) begin
                an_d[idx_q] = 1'b0;
            end
            disp_d = cur_seg;
            dp_d   = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            an_q          <= '1;
            disp_q        <= SEG_OFF;
            dp_q          <= 1'b1;
            fd_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            disp_q  <= disp_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
            if (snap_load) begin
                snap_digits_q <= digits_in;
                snap_dp_q     <= dp_in;
                snap_blank_q  <= blank_mask;
            end
        end
    end

    assign an         = an_q;
    assign disp       = disp_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule
